// File: rtl/spi_shift_engine.sv
// SPI master shift datapath: MOSI shifts on SCK_inter fall, synchronized MISO sampled on rise, word returned with a one-cycle strobe.
// Define SPI_LOOPBACK_EN to feed MOSI into the MISO synchronizer for self-test; MISO is then unused.
module spi_shift_engine #(
   parameter int DATA_WIDTH  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_cpu,
   input  logic                  rst,
   input  logic                  SCK_inter,
   input  logic                  en_SCK,
   input  logic                  load_data,
   input  logic [DATA_WIDTH-1:0] NEW_SPI_DATA_OUT,
   input  logic [1:0]            SPI_DATA_LEN,
   input  logic                  MISO,
   output logic                  MOSI,
   output logic                  done,
   output logic                  load_data_in,
   output logic [DATA_WIDTH-1:0] SPI_DATA_IN_I
);
   localparam int IW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t                 state;
   logic                   sck_q, load_q;
   logic                   rise, fall, start;
   logic                   sync_src, miso_s;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [1:0]             len_q;
   logic [5:0]             bit_cnt, n_start, n_lat;
   logic [IW-1:0]          first_idx, shift_idx;
   logic [DATA_WIDTH-1:0]  tx_sh, rx_sh, rx_mask;

`ifdef SPI_LOOPBACK_EN
   assign sync_src = MOSI;
`else
   assign sync_src = MISO;
`endif

   if (SYNC_STAGES > 1) begin : g_sync_chain
      assign sync_d = {sync_q[SYNC_STAGES-2:0], sync_src};
   end else begin : g_sync_single
      assign sync_d = sync_src;
   end

   always_ff @(posedge clk_cpu or negedge rst) begin
      if (!rst) sync_q <= '0;
      else      sync_q <= sync_d;
   end

   assign miso_s = sync_q[SYNC_STAGES-1];

   assign rise  = SCK_inter & ~sck_q & en_SCK;
   assign fall  = ~SCK_inter & sck_q & en_SCK;
   assign start = load_data & ~load_q;

   // frame length 8*(len+1): 8, 16, 24 or 32
   assign n_start   = 6'({SPI_DATA_LEN, 3'b000}) + 6'd8;
   assign n_lat     = 6'({len_q, 3'b000}) + 6'd8;
   assign first_idx = IW'(n_start - 6'd1);
   assign shift_idx = IW'(bit_cnt - 6'd1);
   assign rx_mask   = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - int'(n_lat));

   always_ff @(posedge clk_cpu or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         sck_q         <= 1'b0;
         load_q        <= 1'b0;
         len_q         <= '0;
         bit_cnt       <= '0;
         tx_sh         <= '0;
         rx_sh         <= '0;
         MOSI          <= 1'b0;
         done          <= 1'b1;
         load_data_in  <= 1'b0;
         SPI_DATA_IN_I <= '0;
      end else begin
         sck_q        <= SCK_inter;
         load_q       <= load_data;
         load_data_in <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  tx_sh   <= NEW_SPI_DATA_OUT;
                  rx_sh   <= '0;
                  len_q   <= SPI_DATA_LEN;
                  bit_cnt <= n_start;
                  MOSI    <= NEW_SPI_DATA_OUT[first_idx];
                  done    <= 1'b0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (rise) begin
                  rx_sh   <= {rx_sh[DATA_WIDTH-2:0], miso_s};
                  bit_cnt <= bit_cnt - 6'd1;
                  if (bit_cnt == 6'd1) state <= FINISH;
               end else if (fall && bit_cnt != 6'd0 && bit_cnt != n_lat) begin
                  // bit_cnt rises remain, so the next bit to present is bit_cnt-1
                  MOSI <= tx_sh[shift_idx];
               end
            end
            FINISH: begin
               SPI_DATA_IN_I <= rx_sh & rx_mask;
               load_data_in  <= 1'b1;
               done          <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: drives SCK_inter as a clk_cpu-synchronous clock and checks MOSI, strobe timing and received words.
module tb_spi_shift_engine;
   localparam int H = 4;
`ifdef SPI_LOOPBACK_EN
   localparam bit LB = 1'b1;
`else
   localparam bit LB = 1'b0;
`endif

   logic        clk_cpu = 1'b0;
   logic        rst = 1'b0;
   logic        SCK_inter = 1'b0;
   logic        en_SCK = 1'b1;
   logic        load_data = 1'b0;
   logic [31:0] NEW_SPI_DATA_OUT = '0;
   logic [1:0]  SPI_DATA_LEN = '0;
   logic        MISO = 1'b0;
   logic        MOSI, done, load_data_in;
   logic [31:0] SPI_DATA_IN_I;

   int checks = 0;
   int errors = 0;
   int strobe_cnt = 0;

   spi_shift_engine #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
      .clk_cpu(clk_cpu), .rst(rst), .SCK_inter(SCK_inter), .en_SCK(en_SCK),
      .load_data(load_data), .NEW_SPI_DATA_OUT(NEW_SPI_DATA_OUT),
      .SPI_DATA_LEN(SPI_DATA_LEN), .MISO(MISO), .MOSI(MOSI), .done(done),
      .load_data_in(load_data_in), .SPI_DATA_IN_I(SPI_DATA_IN_I)
   );

   always #5 clk_cpu = ~clk_cpu;

   always @(negedge clk_cpu) if (load_data_in === 1'b1) strobe_cnt++;

   task automatic tick(input int n);
      repeat (n) @(negedge clk_cpu);
   endtask

   // Runs one frame; reports MOSI bits seen before each rise, whether done/strobe
   // misbehaved mid-frame, and the strobe/done pattern over the 3 cycles after the last rise.
   task automatic run_frame(input logic [1:0] len, input logic [31:0] tx, input logic [31:0] rxp,
                            input int pulse_at, input int stall_at, input int abort_at, input bit hold,
                            output logic [31:0] mosi_w, output bit bad_mid, output bit start_ok,
                            output logic [2:0] strb, output logic [1:0] dseq, output bit aborted);
      int n;
      n = 8 * (int'(len) + 1);
      mosi_w = '0; bad_mid = 1'b0; aborted = 1'b0; strb = '0; dseq = '0;
      SPI_DATA_LEN = len;
      NEW_SPI_DATA_OUT = tx;
      load_data = 1'b1;
      tick(1);
      start_ok = (done === 1'b0);
      if (!hold) load_data = 1'b0;
      SPI_DATA_LEN = ~len;
      NEW_SPI_DATA_OUT = ~tx;
      for (int k = 0; k < n; k++) begin
         MISO = rxp[n-1-k];
         if (k == pulse_at) begin
            load_data = 1'b1; tick(1); load_data = 1'b0;
         end
         if (k == stall_at) begin
            en_SCK = 1'b0; tick(2);
            SCK_inter = 1'b1; tick(8);
            SCK_inter = 1'b0; tick(10);
            if (done !== 1'b0 || load_data_in !== 1'b0) bad_mid = 1'b1;
            en_SCK = 1'b1;
         end
         if (k == abort_at) begin
            rst = 1'b0;
            #1;
            aborted = 1'b1;
            return;
         end
         tick(H);
         mosi_w[n-1-k] = MOSI;
         if (done !== 1'b0 || load_data_in !== 1'b0) bad_mid = 1'b1;
         SCK_inter = 1'b1;
         if (k == n - 1) break;
         tick(H);
         SCK_inter = 1'b0;
      end
      tick(1); strb[2] = load_data_in; dseq[1] = done;
      tick(1); strb[1] = load_data_in; dseq[0] = done;
      tick(1); strb[0] = load_data_in;
      SCK_inter = 1'b0;
      tick(H);
   endtask

   task automatic test_reset;
      tick(2);
      if (done !== 1'b1) begin errors++; $display("FAIL reset_done got %b exp 1", done); end
      checks++;
      if (MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b exp 0", MOSI); end
      checks++;
      if (load_data_in !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0", load_data_in); end
      checks++;
      if (SPI_DATA_IN_I !== 32'h0) begin errors++; $display("FAIL reset_rx got %h exp 0", SPI_DATA_IN_I); end
      checks++;
      rst = 1'b1;
      tick(3);
   endtask

   // Shared per-frame comparisons are written out inline in each scenario below.
   task automatic test_8bit;
      logic [31:0] mw; logic [2:0] st; logic [1:0] ds; bit bm, so, ab; int s0; logic [31:0] ex;
      ex = LB ? 32'h0000_00A5 : 32'h0000_003C;
      s0 = strobe_cnt;
      run_frame(2'b00, 32'h0000_00A5, 32'h0000_003C, -1, -1, -1, 1'b0, mw, bm, so, st, ds, ab);
      if (!so) begin errors++; $display("FAIL b8_start_latency done not low 1 cycle after start"); end
      checks++;
      if (mw !== 32'h0000_00A5) begin errors++; $display("FAIL b8_mosi got %h exp 000000a5", mw); end
      checks++;
      if (bm) begin errors++; $display("FAIL b8_done_low done/strobe asserted mid-frame"); end
      checks++;
      if (st !== 3'b010) begin errors++; $display("FAIL b8_strobe_timing got %b exp 010", st); end
      checks++;
      if (ds !== 2'b01) begin errors++; $display("FAIL b8_done_timing got %b exp 01", ds); end
      checks++;
      if (SPI_DATA_IN_I !== ex) begin errors++; $display("FAIL b8_rx got %h exp %h", SPI_DATA_IN_I, ex); end
      checks++;
      if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL b8_strobe_count got %0d exp 1", strobe_cnt - s0); end
      checks++;
   endtask

   task automatic test_32bit;
      logic [31:0] mw; logic [2:0] st; logic [1:0] ds; bit bm, so, ab; logic [31:0] ex;
      ex = LB ? 32'hDEAD_BEEF : 32'h1234_5678;
      run_frame(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, -1, -1, -1, 1'b0, mw, bm, so, st, ds, ab);
      if (mw !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b32_mosi got %h exp deadbeef", mw); end
      checks++;
      if (bm) begin errors++; $display("FAIL b32_early finished before 32 rises"); end
      checks++;
      if (st !== 3'b010) begin errors++; $display("FAIL b32_strobe_timing got %b exp 010", st); end
      checks++;
      if (SPI_DATA_IN_I !== ex) begin errors++; $display("FAIL b32_rx got %h exp %h", SPI_DATA_IN_I, ex); end
      checks++;
   endtask

   task automatic test_held_load;
      logic [31:0] mw; logic [2:0] st; logic [1:0] ds; bit bm, so, ab, woke; int s0; logic [31:0] ex;
      ex = LB ? 32'h0000_005A : 32'h0000_0081;
      s0 = strobe_cnt;
      woke = 1'b0;
      run_frame(2'b00, 32'h0000_005A, 32'h0000_0081, -1, -1, -1, 1'b1, mw, bm, so, st, ds, ab);
      for (int i = 0; i < 24; i++) begin
         SCK_inter = 1'b1; tick(H);
         if (done !== 1'b1) woke = 1'b1;
         SCK_inter = 1'b0; tick(H);
         if (done !== 1'b1) woke = 1'b1;
      end
      load_data = 1'b0;
      tick(2);
      if (SPI_DATA_IN_I !== ex) begin errors++; $display("FAIL held_rx got %h exp %h", SPI_DATA_IN_I, ex); end
      checks++;
      if (woke) begin errors++; $display("FAIL held_restart done dropped while load_data held"); end
      checks++;
      if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL held_strobe_count got %0d exp 1", strobe_cnt - s0); end
      checks++;
   endtask

   task automatic test_ignored_restart;
      logic [31:0] mw; logic [2:0] st; logic [1:0] ds; bit bm, so, ab; int s0; logic [31:0] ex;
      ex = LB ? 32'h0000_1234 : 32'h0000_9C6E;
      s0 = strobe_cnt;
      run_frame(2'b01, 32'hABCD_1234, 32'hFFFF_9C6E, 5, -1, -1, 1'b0, mw, bm, so, st, ds, ab);
      if (mw !== 32'h0000_1234) begin errors++; $display("FAIL b16_mosi got %h exp 00001234", mw); end
      checks++;
      if (bm) begin errors++; $display("FAIL b16_restart frame disturbed by second pulse"); end
      checks++;
      if (SPI_DATA_IN_I !== ex) begin errors++; $display("FAIL b16_rx got %h exp %h", SPI_DATA_IN_I, ex); end
      checks++;
      if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL b16_strobe_count got %0d exp 1", strobe_cnt - s0); end
      checks++;
   endtask

   task automatic test_reset_abort;
      logic [31:0] mw; logic [2:0] st; logic [1:0] ds; bit bm, so, ab; int s0; logic [31:0] ex;
      s0 = strobe_cnt;
      run_frame(2'b10, 32'h00F0_F0F0, 32'h0055_AA55, -1, -1, 10, 1'b0, mw, bm, so, st, ds, ab);
      if (done !== 1'b1) begin errors++; $display("FAIL abort_done got %b exp 1", done); end
      checks++;
      if (MOSI !== 1'b0) begin errors++; $display("FAIL abort_mosi got %b exp 0", MOSI); end
      checks++;
      if (SPI_DATA_IN_I !== 32'h0) begin errors++; $display("FAIL abort_rx got %h exp 0", SPI_DATA_IN_I); end
      checks++;
      tick(3);
      rst = 1'b1;
      tick(3);
      if (strobe_cnt - s0 != 0) begin errors++; $display("FAIL abort_strobe got %0d exp 0", strobe_cnt - s0); end
      checks++;
      ex = LB ? 32'h0000_0096 : 32'h0000_0069;
      run_frame(2'b00, 32'h0000_0096, 32'h0000_0069, -1, -1, -1, 1'b0, mw, bm, so, st, ds, ab);
      if (mw !== 32'h0000_0096) begin errors++; $display("FAIL post_abort_mosi got %h exp 00000096", mw); end
      checks++;
      if (SPI_DATA_IN_I !== ex) begin errors++; $display("FAIL post_abort_rx got %h exp %h", SPI_DATA_IN_I, ex); end
      checks++;
   endtask

   task automatic test_stall;
      logic [31:0] mw; logic [2:0] st; logic [1:0] ds; bit bm, so, ab; int s0;
      s0 = strobe_cnt;
      run_frame(2'b01, 32'h0000_C3A5, 32'h0000_C3A5, -1, 7, -1, 1'b0, mw, bm, so, st, ds, ab);
      if (mw !== 32'h0000_C3A5) begin errors++; $display("FAIL stall_mosi got %h exp 0000c3a5", mw); end
      checks++;
      if (bm) begin errors++; $display("FAIL stall_done frame ended or strobed during stall"); end
      checks++;
      if (SPI_DATA_IN_I !== 32'h0000_C3A5) begin errors++; $display("FAIL stall_rx got %h exp 0000c3a5", SPI_DATA_IN_I); end
      checks++;
      if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL stall_strobe_count got %0d exp 1", strobe_cnt - s0); end
      checks++;
   endtask

   initial begin
      test_reset();
      test_8bit();
      test_32bit();
      test_held_load();
      test_ignored_restart();
      test_reset_abort();
      test_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
Serial shift datapath of the SPI master. It consumes the control outputs of spi_logic_control (load_data, SCK_inter, en_SCK, NEW_SPI_DATA_OUT, SPI_DATA_LEN) and drives MOSI and samples MISO. It returns done (drives SS), a one-cycle load_data_in strobe and the received word SPI_DATA_IN_I for bit-order correction. Fully synchronous to clk_cpu; SCK_inter edges are detected as clk_cpu-domain events (the divider output is synchronous to clk_cpu).

Parameters:
DATA_WIDTH, 32, width of tx/rx words; SPI_DATA_LEN selects 8/16/24/32 of it.
SYNC_STAGES, 2, flops in the MISO synchronizer (minimum 1).

Ports:
clk_cpu  input  1  system clock, only clock of the block.
rst  input  1  asynchronous active-low reset: rst=0 resets immediately, release synchronous to clk_cpu.
SCK_inter  input  1  mode-adjusted internal SPI clock; rising edge = sample, falling edge = shift.
en_SCK  input  1  SCK_inter edges counted only while 1.
load_data  input  1  level from control FSM; its 0->1 transition starts a transfer.
NEW_SPI_DATA_OUT  input  DATA_WIDTH  order-corrected word to transmit.
SPI_DATA_LEN  input  2  00=8, 01=16, 10=24, 11=32 bits; sampled at start.
MISO  input  1  serial data in (asynchronous).
MOSI  output  1  serial data out.
done  output  1  1 = idle/finished (SS deasserted), 0 = transfer in progress.
load_data_in  output  1  one-cycle strobe, SPI_DATA_IN_I valid.
SPI_DATA_IN_I  output  DATA_WIDTH  received word, zero-extended above N bits.

Behaviour:
- Reset: MOSI=0, done=1, load_data_in=0, SPI_DATA_IN_I=0, state IDLE, shift registers and counter 0, edge-detect history 0, synchronizer 0.
- N = 8*(SPI_DATA_LEN+1), latched at start; later changes of SPI_DATA_LEN ignored until next start.
- Edge detect: sck_q = SCK_inter registered. rise = SCK_inter & ~sck_q & en_SCK; fall = ~SCK_inter & sck_q & en_SCK.
- States IDLE, SHIFT, FINISH.
- IDLE: on cycle where load_data=1 and previous-cycle load_data=0: next cycle tx_sh <= NEW_SPI_DATA_OUT, bit_cnt <= N, MOSI <= NEW_SPI_DATA_OUT[N-1], done <= 0, state SHIFT. Level-held load_data never restarts.
- SHIFT: rise -> rx_sh <= {rx_sh, miso_s}, bit_cnt <= bit_cnt-1. fall with bit_cnt != 0 and bit_cnt != N -> MOSI <= next lower bit (MSB-first within N bits). Transition to FINISH on the cycle bit_cnt becomes 0.
- FINISH (one cycle): SPI_DATA_IN_I <= rx_sh[N-1:0] zero-extended, load_data_in=1 for exactly that cycle, done <= 1, MOSI held at last bit, then IDLE.
- Latency: start edge -> done=0 in 1 cycle; last rise -> load_data_in in 2 cycles.
- load_data 0->1 while in SHIFT or FINISH: ignored, no queuing.
- en_SCK=0 mid-transfer: transfer stalls with state held; resumes when en_SCK returns.
- rise and fall cannot occur in the same cycle; if SCK_inter toggles faster than clk_cpu/2, behaviour is undefined.
- rst asserted mid-transfer: abort, all outputs to reset values immediately, no load_data_in strobe.
- SPI_DATA_IN_I holds its value until the next FINISH.
- miso_s is MISO delayed by SYNC_STAGES flops. The SCK half-period must be at least SYNC_STAGES+1 clk_cpu cycles.

Optional Feature:
SPI_LOOPBACK_EN: when defined, the synchronizer input is MOSI instead of MISO (internal loopback for self-test), and MISO is unused. When undefined, MISO is used and there is no loopback logic.

Test Plan:
- 8-bit transfer: LEN=00, NEW_SPI_DATA_OUT=0x000000A5, MISO drives 0x3C MSB-first on rises -> MOSI 1,0,1,0,0,1,0,1; done low for the whole frame; load_data_in 1 cycle; SPI_DATA_IN_I=0x0000003C.
- 32-bit transfer: LEN=11, tx=0xDEADBEEF, MISO=0x12345678 -> exactly 32 rises counted; SPI_DATA_IN_I=0x12345678; MOSI sequence equals 0xDEADBEEF MSB-first.
- load_data held high for 3 frames' worth of SCK after completion -> exactly one transfer and one load_data_in; done stays 1.
- Second load_data 0->1 pulse at bit 5 of a 16-bit frame -> ignored; frame completes after 16 rises; single strobe.
- rst=0 at bit 10 of a 24-bit frame -> done=1, MOSI=0, SPI_DATA_IN_I=0 asynchronously; new transfer after release behaves normally.
- With SPI_LOOPBACK_EN, LEN=01, tx=0x0000C3A5 -> SPI_DATA_IN_I=0x0000C3A5 regardless of MISO; en_SCK dropped for 20 cycles mid-frame -> same result, completion delayed.
